// File: rtl/canny_frame_arbiter_if.sv
// Handshake bundle between canny_frame_arbiter, the two pixel sources/sinks and the
// shared canny pipeline FIFOs. master = arbiter side, slave = environment side.
interface canny_frame_arbiter_if;
   logic [1:0]  req;
   logic        src0_empty;
   logic        src1_empty;
   logic [23:0] src0_dout;
   logic [23:0] src1_dout;
   logic        src0_rd_en;
   logic        src1_rd_en;
   logic        image_full;
   logic        image_wr_en;
   logic [23:0] image_din;
   logic        img_out_empty;
   logic [7:0]  img_out_dout;
   logic        img_out_rd_en;
   logic        snk0_full;
   logic        snk1_full;
   logic        snk0_wr_en;
   logic        snk1_wr_en;
   logic [7:0]  snk0_din;
   logic [7:0]  snk1_din;
   logic [1:0]  grant;
   logic        busy;
   logic        frame_done;
   logic        done_id;
   logic        error;

   modport master (
      input  req, src0_empty, src1_empty, src0_dout, src1_dout, image_full,
             img_out_empty, img_out_dout, snk0_full, snk1_full,
      output src0_rd_en, src1_rd_en, image_wr_en, image_din, img_out_rd_en,
             snk0_wr_en, snk1_wr_en, snk0_din, snk1_din, grant, busy, frame_done,
             done_id, error
   );

   modport slave (
      output req, src0_empty, src1_empty, src0_dout, src1_dout, image_full,
             img_out_empty, img_out_dout, snk0_full, snk1_full,
      input  src0_rd_en, src1_rd_en, image_wr_en, image_din, img_out_rd_en,
             snk0_wr_en, snk1_wr_en, snk0_din, snk1_din, grant, busy, frame_done,
             done_id, error
   );
endinterface

// File: rtl/canny_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one canny pipeline between two requesters.
// Optional FRAME_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYCLES idle cycles.
module canny_frame_arbiter #(
   parameter int unsigned WIDTH          = 1280,
   parameter int unsigned HEIGHT         = 720,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input logic                  clock,
   input logic                  reset,
   canny_frame_arbiter_if.master bus
);
   localparam int unsigned N  = WIDTH * HEIGHT;
   localparam int unsigned CW = $clog2(N + 1);
   localparam logic [CW-1:0] NMax  = CW'(N);
   localparam logic [CW-1:0] NLast = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StStream, StDone} state_e;

   state_e          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [1:0]      grant_q, grant_d;
   logic            busy_q, busy_d;
   logic            done_id_q, done_id_d;
   logic            error_q, error_d;
   logic            streaming, src_empty, snk_full, xfer_in, xfer_out, timeout;

   assign streaming = (state_q == StStream);
   assign src_empty = owner_q ? bus.src1_empty : bus.src0_empty;
   assign snk_full  = owner_q ? bus.snk1_full  : bus.snk0_full;
   assign xfer_in   = streaming && (in_cnt_q < NMax) && !src_empty && !bus.image_full;
   assign xfer_out  = streaming && (out_cnt_q < NMax) && !bus.img_out_empty && !snk_full;

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SW-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = '0;
      timeout = 1'b0;
      if (streaming) begin
         if (xfer_in || xfer_out) begin
            stall_d = '0;
         end else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
         end else begin
            stall_d = stall_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      done_id_d = done_id_q;
      error_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req != 2'b00) begin
               state_d = StGrant;
               case (bus.req)
                  2'b01:   owner_d = 1'b0;
                  2'b10:   owner_d = 1'b1;
                  default: owner_d = ~last_q;
               endcase
            end
         end
         StGrant: begin
            grant_d   = owner_q ? 2'b10 : 2'b01;
            busy_d    = 1'b1;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = StStream;
         end
         StStream: begin
            if (xfer_in)  in_cnt_d  = in_cnt_q + CW'(1);
            if (xfer_out) out_cnt_d = out_cnt_q + CW'(1);
            if (xfer_out && (out_cnt_q == NLast)) begin
               done_id_d = owner_q;
               state_d   = StDone;
            end else if (timeout) begin
               error_d   = 1'b1;
               grant_d   = 2'b00;
               busy_d    = 1'b0;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               last_d    = owner_q;
               state_d   = StIdle;
            end
         end
         StDone: begin
            last_d  = owner_q;
            grant_d = 2'b00;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // last resets to 1 so requester 0 wins the first contested arbitration.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         grant_q   <= 2'b00;
         busy_q    <= 1'b0;
         done_id_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         done_id_q <= done_id_d;
         error_q   <= error_d;
      end
   end

   assign bus.src0_rd_en    = xfer_in & ~owner_q;
   assign bus.src1_rd_en    = xfer_in & owner_q;
   assign bus.image_wr_en   = xfer_in;
   assign bus.image_din     = owner_q ? bus.src1_dout : bus.src0_dout;
   assign bus.img_out_rd_en = xfer_out;
   assign bus.snk0_wr_en    = xfer_out & ~owner_q;
   assign bus.snk1_wr_en    = xfer_out & owner_q;
   assign bus.snk0_din      = bus.img_out_dout;
   assign bus.snk1_din      = bus.img_out_dout;
   assign bus.grant         = grant_q;
   assign bus.busy          = busy_q;
   assign bus.frame_done    = (state_q == StDone);
   assign bus.done_id       = done_id_q;
   assign bus.error         = error_q;
endmodule
